// File: rtl/uart_cfg_pkg.sv
// Shared constants, FSM states and reset-divisor helper for the UART config regfile.
package uart_cfg_pkg;

  localparam int BAUD_W = 20;
  localparam int DIV_W  = 32;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_ISR  = 2'd1;
  localparam logic [1:0] REG_BAUD = 2'd2;
  localparam logic [1:0] REG_CD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } fsm_e;

  function automatic logic [DIV_W-1:0] rst_cd(
    input logic [DIV_W-1:0] clk_hz,
    input int               os,
    input logic [DIV_W-1:0] baud,
    input int               cd_w
  );
    logic [DIV_W-1:0] q;
    logic [DIV_W-1:0] max;
    q   = clk_hz / (DIV_W'(os) * baud);
    max = (DIV_W'(1) << cd_w) - DIV_W'(1);
    if (q == '0)
      return DIV_W'(1);
    if (q > max)
      return max;
    return q;
  endfunction

endpackage

// File: rtl/uart_cfg_regfile_if.sv
// APB slave bus bundle for the UART config regfile.
interface uart_cfg_regfile_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/uart_baud_div.sv
// 32-bit restoring divider, one quotient bit per cycle, saturating CD_W result.
module uart_baud_div
  import uart_cfg_pkg::*;
#(
  parameter int CD_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [CD_W-1:0]  cd
);

  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] dvs;
  logic [4:0]       cnt;
  logic [DIV_W:0]   shl;
  logic [DIV_W+1:0] trial;
  logic             unused;

  assign shl    = {rem, quo[DIV_W-1]};
  assign trial  = {1'b0, shl} - {2'b00, dvs};
  assign done   = busy && (cnt == 5'd31);
  assign unused = trial[DIV_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      if (!trial[DIV_W+1]) begin
        rem <= trial[DIV_W-1:0];
        quo <= {quo[DIV_W-2:0], 1'b1};
      end else begin
        rem <= shl[DIV_W-1:0];
        quo <= {quo[DIV_W-2:0], 1'b0};
      end
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31)
        busy <= 1'b0;
    end
  end

  // Zero would stall the baud generator; overflow clamps to the slowest rate.
  always_comb begin
    cd = quo[CD_W-1:0];
    if (quo == '0)
      cd = CD_W'(1);
    else if (|quo[DIV_W-1:CD_W])
      cd = '1;
  end

endmodule

// File: rtl/uart_cfg_regfile.sv
// Multi-channel UART config regfile on APB; divisor derived from written baud.
// Define UART_CFG_DIRECT_CD_EN to make the CD register directly writable.
module uart_cfg_regfile
  import uart_cfg_pkg::*;
#(
  parameter int              NUM_CH     = 2,
  parameter logic [31:0]     CLK_HZ     = 32'd50000000,
  parameter int              OVERSAMPLE = 16,
  parameter int              CTRL_W     = 7,
  parameter int              CD_W       = 13,
  parameter logic [CTRL_W-1:0] CTRL_RST = 7'b000_0011,
  parameter int              BAUD_RST   = 115200
) (
  input  logic                     CLK,
  input  logic                     RESET,
  uart_cfg_regfile_if.slave        apb,
  input  logic [2*NUM_CH-1:0]      state_isr_i,
  output logic [CTRL_W*NUM_CH-1:0] ctrl_o,
  output logic [4*NUM_CH-1:0]      state_isr_o,
  output logic [CD_W*NUM_CH-1:0]   cd_o,
  output logic                     busy_o
);

`ifdef UART_CFG_DIRECT_CD_EN
  localparam bit DIRECT_CD = 1'b1;
`else
  localparam bit DIRECT_CD = 1'b0;
`endif

  localparam logic [CD_W-1:0] CD_RST =
    CD_W'(rst_cd(CLK_HZ, OVERSAMPLE, DIV_W'(BAUD_RST), CD_W));
  localparam logic [BAUD_W-1:0] BAUD_RV = BAUD_W'(BAUD_RST);

  fsm_e              state;
  logic [CTRL_W-1:0] ctrl_q [NUM_CH];
  logic [1:0]        ien_q  [NUM_CH];
  logic [1:0]        sts_q  [NUM_CH];
  logic [BAUD_W-1:0] baud_q [NUM_CH];
  logic [CD_W-1:0]   cd_q   [NUM_CH];
  logic [3:0]        tgt_ch;
  logic [BAUD_W-1:0] tgt_baud;

  logic [3:0]        ch;
  logic [1:0]        roff;
  logic              ch_ok;
  logic              acc;
  logic              err;
  logic              wr_ok;
  logic              start;
  logic [31:0]       rdata;
  logic [DIV_W-1:0]  dvs;
  logic              div_busy;
  logic              div_done;
  logic [CD_W-1:0]   div_cd;
  logic              unused;

  assign ch     = apb.PADDR[7:4];
  assign roff   = apb.PADDR[3:2];
  assign ch_ok  = ({1'b0, ch} < 5'(NUM_CH));
  assign acc    = apb.PSEL && apb.PENABLE && (state == IDLE);
  assign unused = ^{apb.PADDR[1:0], div_busy};

  always_comb begin
    err = !ch_ok;
    if (apb.PWRITE) begin
      case (roff)
        REG_BAUD:
          if (apb.PWDATA[31:BAUD_W] != '0 ||
              apb.PWDATA[BAUD_W-1:0] == '0)
            err = 1'b1;
        REG_CD:
          if (!DIRECT_CD || apb.PWDATA[CD_W-1:0] == '0)
            err = 1'b1;
        default: ;
      endcase
    end
  end

  assign wr_ok = acc && apb.PWRITE && !err;
  assign start = wr_ok && (roff == REG_BAUD);
  assign dvs   = DIV_W'(OVERSAMPLE) * DIV_W'(apb.PWDATA[BAUD_W-1:0]);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 4'(i)) begin
        case (roff)
          REG_CTRL: rdata = 32'(ctrl_q[i]);
          REG_ISR:  rdata = 32'({ien_q[i], sts_q[i]});
          REG_BAUD: rdata = 32'(baud_q[i]);
          default:  rdata = 32'(cd_q[i]);
        endcase
      end
    end
  end

  // A BAUD write holds PREADY low from its first access cycle until DONE.
  always_comb begin
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = '0;
    unique case (state)
      IDLE: begin
        apb.PREADY  = !start;
        apb.PSLVERR = acc && err;
        if (acc && !apb.PWRITE && !err)
          apb.PRDATA = rdata;
      end
      DONE:    apb.PREADY = 1'b1;
      default: apb.PREADY = 1'b0;
    endcase
  end

  uart_baud_div #(
    .CD_W (CD_W)
  ) u_div (
    .clk      (CLK),
    .rst      (RESET),
    .start    (start),
    .dividend (CLK_HZ),
    .divisor  (dvs),
    .busy     (div_busy),
    .done     (div_done),
    .cd       (div_cd)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      tgt_ch   <= '0;
      tgt_baud <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl_q[i] <= CTRL_RST;
        ien_q[i]  <= '0;
        sts_q[i]  <= '0;
        baud_q[i] <= BAUD_RV;
        cd_q[i]   <= CD_RST;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        sts_q[i] <= state_isr_i[2*i +: 2];
      unique case (state)
        IDLE: begin
          if (wr_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch == 4'(i)) begin
                case (roff)
                  REG_CTRL: ctrl_q[i] <= apb.PWDATA[CTRL_W-1:0];
                  REG_ISR:  ien_q[i]  <= apb.PWDATA[3:2];
                  REG_CD:   cd_q[i]   <= apb.PWDATA[CD_W-1:0];
                  default:  ;
                endcase
              end
            end
          end
          if (start) begin
            state    <= DIV;
            busy_o   <= 1'b1;
            tgt_ch   <= ch;
            tgt_baud <= apb.PWDATA[BAUD_W-1:0];
          end
        end
        DIV: begin
          if (div_done) begin
            state  <= DONE;
            busy_o <= 1'b0;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (tgt_ch == 4'(i)) begin
              baud_q[i] <= tgt_baud;
              cd_q[i]   <= div_cd;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_o      = '0;
    state_isr_o = '0;
    cd_o        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_o[i*CTRL_W +: CTRL_W] = ctrl_q[i];
      state_isr_o[4*i +: 4]      = {ien_q[i], sts_q[i]};
      cd_o[i*CD_W +: CD_W]       = cd_q[i];
    end
  end

endmodule

// File: tb/tb_uart_cfg_regfile.sv
// Directed bench for uart_cfg_regfile: APB register access, baud division, errors.
module tb_uart_cfg_regfile;

  logic        clk;
  logic        rst;
  logic [3:0]  state_isr_i;
  logic [13:0] ctrl_o;
  logic [7:0]  state_isr_o;
  logic [25:0] cd_o;
  logic        busy_o;

  int errs;
  int checks;

  uart_cfg_regfile_if bus ();

  uart_cfg_regfile dut (
    .CLK         (clk),
    .RESET       (rst),
    .apb         (bus),
    .state_isr_i (state_isr_i),
    .ctrl_o      (ctrl_o),
    .state_isr_o (state_isr_o),
    .cd_o        (cd_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] addr(input int c, input int r);
    return {4'(c), 2'(r), 2'b00};
  endfunction

  task automatic xfer(input bit wr, input logic [7:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int waits,
                      output int busy_n);
    bit fin;
    fin    = 1'b0;
    waits  = 0;
    busy_n = 0;
    rd     = '0;
    er     = 1'b0;
    @(posedge clk);
    #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    @(posedge clk);
    #1;
    bus.PENABLE = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy_o)
        busy_n++;
      if (bus.PREADY) begin
        fin = 1'b1;
        rd  = bus.PRDATA;
        er  = bus.PSLVERR;
        break;
      end
      waits++;
    end
    if (!fin)
      chk("pready_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          w;
  int          bn;

  task automatic baud_case(input string tag, input int c,
                           input logic [31:0] baud, input int exp_cd);
    xfer(1'b1, addr(c, 2), baud, rd, er, w, bn);
    chk({tag, "_err"}, 32'(er), 32'd0);
    chk({tag, "_waits"}, 32'(w), 32'd33);
    chk({tag, "_cd"}, 32'(cd_o[c*13 +: 13]), 32'(exp_cd));
  endtask

  initial begin
    errs        = 0;
    checks      = 0;
    rst         = 1'b1;
    state_isr_i = 4'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    chk("rst_ctrl0", 32'(ctrl_o[6:0]), 32'h03);
    chk("rst_ctrl1", 32'(ctrl_o[13:7]), 32'h03);
    chk("rst_cd0", 32'(cd_o[12:0]), 32'd27);
    chk("rst_cd1", 32'(cd_o[25:13]), 32'd27);
    chk("rst_ien0", 32'(state_isr_o[3:2]), 32'd0);
    chk("rst_ien1", 32'(state_isr_o[7:6]), 32'd0);
    chk("rst_pready", 32'(bus.PREADY), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_prdata", bus.PRDATA, 32'd0);

    xfer(1'b1, addr(0, 0), 32'h55, rd, er, w, bn);
    chk("ctrl_wr_waits", 32'(w), 32'd0);
    chk("ctrl_wr_err", 32'(er), 32'd0);
    chk("ctrl0_out", 32'(ctrl_o[6:0]), 32'h55);
    chk("ctrl1_keep", 32'(ctrl_o[13:7]), 32'h03);
    xfer(1'b0, addr(0, 0), 32'h0, rd, er, w, bn);
    chk("ctrl_rd", rd, 32'h55);
    chk("ctrl_rd_waits", 32'(w), 32'd0);

    state_isr_i = 4'b10_01;
    xfer(1'b1, addr(0, 1), 32'hF, rd, er, w, bn);
    chk("isr0_out", 32'(state_isr_o[3:0]), 32'hD);
    chk("isr1_out", 32'(state_isr_o[7:4]), 32'h2);
    xfer(1'b0, addr(0, 1), 32'h0, rd, er, w, bn);
    chk("isr0_rd", rd, 32'hD);

    xfer(1'b1, addr(1, 2), 32'd9600, rd, er, w, bn);
    chk("b9600_waits", 32'(w), 32'd33);
    chk("b9600_busy", 32'(bn), 32'd32);
    chk("b9600_err", 32'(er), 32'd0);
    chk("b9600_cd1", 32'(cd_o[25:13]), 32'd325);
    chk("b9600_cd0", 32'(cd_o[12:0]), 32'd27);
    xfer(1'b0, addr(1, 2), 32'h0, rd, er, w, bn);
    chk("b9600_rd", rd, 32'd9600);
    xfer(1'b0, addr(1, 3), 32'h0, rd, er, w, bn);
    chk("cd1_rd", rd, 32'd325);

    xfer(1'b1, addr(0, 2), 32'd0, rd, er, w, bn);
    chk("baud0_err", 32'(er), 32'd1);
    chk("baud0_waits", 32'(w), 32'd0);
    chk("baud0_cd", 32'(cd_o[12:0]), 32'd27);
    xfer(1'b1, addr(0, 2), 32'h0010_0000, rd, er, w, bn);
    chk("baudbig_err", 32'(er), 32'd1);
    chk("baudbig_cd", 32'(cd_o[12:0]), 32'd27);
    xfer(1'b0, addr(2, 0), 32'h0, rd, er, w, bn);
    chk("ch2_err", 32'(er), 32'd1);
    chk("ch2_prdata", rd, 32'd0);
    xfer(1'b1, addr(2, 0), 32'h11, rd, er, w, bn);
    chk("ch2_wr_err", 32'(er), 32'd1);
    chk("ch2_wr_ctrl", 32'(ctrl_o), 32'({7'h03, 7'h55}));
    xfer(1'b1, addr(0, 3), 32'd5, rd, er, w, bn);
    chk("cdwr_err", 32'(er), 32'd1);
    chk("cdwr_cd", 32'(cd_o[12:0]), 32'd27);
    xfer(1'b0, addr(0, 2), 32'h0, rd, er, w, bn);
    chk("baud0_keep", rd, 32'd115200);

    baud_case("b600", 0, 32'd600, 5208);
    baud_case("b921600", 0, 32'd921600, 3);
    baud_case("b1", 0, 32'd1, 8191);
    chk("b1_cd1_keep", 32'(cd_o[25:13]), 32'd325);

    @(posedge clk);
    #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = addr(0, 2);
    bus.PWDATA  = 32'd4800;
    @(posedge clk);
    #1 bus.PENABLE = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy_o), 32'd1);
    chk("abort_pready_pre", 32'(bus.PREADY), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge clk);
    chk("abort_cd0", 32'(cd_o[12:0]), 32'd27);
    chk("abort_cd1", 32'(cd_o[25:13]), 32'd27);
    chk("abort_pready", 32'(bus.PREADY), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_ctrl0", 32'(ctrl_o[6:0]), 32'h03);
    repeat (40) @(negedge clk);
    chk("abort_cd0_late", 32'(cd_o[12:0]), 32'd27);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_cfg_regfile.md
Name: uart_cfg_regfile

Overview:
- Parametrised, multi-channel UART configuration register file with an APB slave port.
- Per channel it holds the control word, the interrupt-enable/status register and the clock divisor.
- The divisor is computed at runtime from a written baud rate by a sequential divider, instead of a fixed lookup table.
- Sits between the APB bus and NUM_CH UART TX/RX cores, and drives their config buses.

Parameters:
- NUM_CH, 2, number of UART channels (1..16).
- CLK_HZ, 50000000, CLK frequency in Hz (32-bit).
- OVERSAMPLE, 16, receiver oversampling factor.
- CTRL_W, 7, control word width.
- CD_W, 13, divisor width.
- CTRL_RST, 7'b000_0011, control reset value.
- BAUD_RST, 115200, reset baud rate; reset divisor = CLK_HZ/(OVERSAMPLE*BAUD_RST) truncated, which is 27 at defaults.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB direction.
- PADDR  in  8  byte address: [7:4] channel, [3:2] register, [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid when PREADY=1.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error, valid when PREADY=1.
- state_isr_i  in  2*NUM_CH  per-channel live status bits.
- ctrl_o  out  CTRL_W*NUM_CH  per-channel control.
- state_isr_o  out  4*NUM_CH  per-channel {enables[1:0], status[1:0]}.
- cd_o  out  CD_W*NUM_CH  per-channel divisor.
- busy_o  out  1  divider running.

Behaviour:
- Reset (RESET high at a CLK edge, takes effect regardless of bus activity), for every channel:
  - ctrl_o=CTRL_RST; enables=0; cd_o=reset divisor; baud register=BAUD_RST.
  - FSM→IDLE; PREADY=1; PSLVERR=0; PRDATA=0; busy_o=0.
- Register map per channel, offset in PADDR[3:2]:
  - 0 CTRL: RW, CTRL_W bits.
  - 1 ISR: bits[3:2] RW; bits[1:0] RO.
  - 2 BAUD: RW, 20 bits.
  - 3 CD: RO.
  - Unused read bits return 0.
- state_isr_o[1:0] of each channel is state_isr_i registered every cycle (1-cycle latency). Writes to these bits are ignored.
- APB protocol:
  - Setup phase: PSEL & !PENABLE.
  - Access phase: PSEL & PENABLE.
  - Reads and CTRL/ISR writes complete in the first access cycle with PREADY=1. Write data is visible on outputs the next cycle.
- Errors (PSLVERR=1 for the completing cycle, no state change):
  - channel ≥ NUM_CH;
  - write to CD;
  - BAUD write of 0;
  - BAUD write > 20'hFFFFF, i.e. PWDATA[31:20]≠0.
- FSM IDLE/DIV/DONE:
  - IDLE: a valid BAUD write in its access cycle N drives PREADY=0, loads the divider (dividend CLK_HZ, divisor OVERSAMPLE*baud, 32-bit) and moves to DIV.
  - DIV: restoring division, one quotient bit per cycle for 32 cycles. busy_o=1. PREADY=0.
  - DONE: lasts one cycle, N+33. PREADY=1. At its closing edge the baud register and cd_o of the addressed channel are updated. FSM→IDLE.
  - Total: 33 wait states; new cd_o visible from N+34.
- Quotient rules:
  - Truncated.
  - 0 → saturates to 1.
  - > 2^CD_W-1 → saturates to 2^CD_W-1.
  - Saturation is not an error.
- Other channels' outputs are unaffected by any division.
- Setup-phase signals are ignored while in DIV; APB guarantees no new transfer.
- RESET during DIV/DONE: division is aborted and the target channel keeps its reset values.

Optional Feature:
- UART_CFG_DIRECT_CD_EN.
- Defined: CD (offset 3) is RW. Write takes PWDATA[CD_W-1:0] in zero wait states. Value 0 → PSLVERR, no change. The BAUD register is not changed.
- Undefined: CD is RO, and a write to it gives PSLVERR.

Decomposition:
- Package uart_cfg_pkg holds:
  - register offset constants (CTRL/ISR/BAUD/CD);
  - FSM enum {IDLE,DIV,DONE};
  - reset-divisor constant function;
  - field widths for baud (20) and the dividend (32).
- One sub-module uart_baud_div: start/busy/done handshake, 32-bit restoring divider, saturating CD_W output.

Test Plan:
- Reset → every channel: ctrl_o=7'h03, cd_o=27, state_isr_o[3:2]=0; PREADY=1.
- Write CTRL ch0=7'h55, read back → ctrl_o[6:0]=7'h55, PRDATA=32'h55, zero wait states; ch1 still 7'h03.
- Write BAUD ch1=9600 → PREADY low exactly 33 cycles, busy_o high 32 cycles; then cd_o ch1=325, BAUD readback=9600.
- BAUD write 0, read of channel 2 with NUM_CH=2, or write to CD (macro undefined) → PSLVERR=1 with PREADY=1, all outputs unchanged.
- BAUD 600 → cd=5208. BAUD 921600 → cd=3. BAUD 1 → cd saturates to 8191.
- RESET asserted at DIV cycle 10 of a ch0 BAUD=4800 write → next cycle FSM IDLE, cd_o ch0=27, PREADY=1, busy_o=0.
